// File: rtl/led_pattern_gen.sv
// LED pattern generator: divided step clock driving binary, Gray, scan
// and PWM-breathe patterns, with hold, step pulse and heartbeat outputs.
module led_pattern_gen #(
    parameter int CLK_HZ       = 12000000,
    parameter int STEP_HZ      = 8,
    parameter int N_LEDS       = 4,
    parameter int PWM_BITS     = 8,
    parameter int BREATHE_STEP = 16
) (
    input  logic              CLK_IN,
    input  logic              RST_N_IN,
    input  logic [1:0]        MODE_IN,
    input  logic              HOLD_IN,
    output logic [N_LEDS-1:0] LED_OUT,
    output logic              HB_LED_OUT,
    output logic              STEP_OUT
);

    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int BW  = PWM_BITS + 1;

    localparam logic [PW-1:0]       PRE_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0]       POS_LAST = SW'(N_LEDS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [BW-1:0]       STEP_W   = BW'(BREATHE_STEP);

    if (DIV < 2) begin : g_div_chk
        $error("led_pattern_gen: CLK_HZ/STEP_HZ must be >= 2");
    end
    if (N_LEDS < 1 || N_LEDS > 16) begin : g_led_chk
        $error("led_pattern_gen: N_LEDS must be 1..16");
    end
    if (PWM_BITS < 2 || PWM_BITS > 12) begin : g_pwm_chk
        $error("led_pattern_gen: PWM_BITS must be 2..12");
    end
    if (BREATHE_STEP < 1 || BREATHE_STEP >= (1 << PWM_BITS)) begin : g_bs_chk
        $error("led_pattern_gen: BREATHE_STEP out of range");
    end

    typedef enum logic [1:0] {
        M_BIN     = 2'd0,
        M_GRAY    = 2'd1,
        M_SCAN    = 2'd2,
        M_BREATHE = 2'd3
    } mode_t;

    logic [1:0]          mode_s1;
    logic [1:0]          mode_s2;
    mode_t               mode_q;
    logic [PW-1:0]       pre;
    logic [N_LEDS-1:0]   cnt;
    logic [SW-1:0]       pos;
    logic                scan_down;
    logic [PWM_BITS-1:0] duty;
    logic                br_down;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic                change;
    logic                tick;
    logic [BW-1:0]       duty_up;
    logic [N_LEDS-1:0]   pat;

    // A mode change pre-empts any tick landing in the same cycle.
    assign change  = (mode_t'(mode_s2) != mode_q);
    assign tick    = (pre == PRE_LAST) && !HOLD_IN && !change;
    assign duty_up = {1'b0, duty} + STEP_W;

    always_comb begin
        pat = '0;
        unique case (mode_q)
            M_BIN:     pat = cnt;
            M_GRAY:    pat = cnt ^ (cnt >> 1);
            M_SCAN:    pat = N_LEDS'(1) << pos;
            M_BREATHE: pat = {N_LEDS{pwm_cnt < duty}};
            default:   pat = '0;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            mode_s1    <= '0;
            mode_s2    <= '0;
            mode_q     <= M_BIN;
            pre        <= '0;
            cnt        <= '0;
            pos        <= '0;
            scan_down  <= 1'b0;
            duty       <= '0;
            br_down    <= 1'b0;
            pwm_cnt    <= '0;
            LED_OUT    <= '0;
            HB_LED_OUT <= 1'b0;
            STEP_OUT   <= 1'b0;
        end else begin
            mode_s1  <= MODE_IN;
            mode_s2  <= mode_s1;
            mode_q   <= mode_t'(mode_s2);
            pwm_cnt  <= pwm_cnt + 1'b1;
            LED_OUT  <= pat;
            STEP_OUT <= tick;
            if (tick) HB_LED_OUT <= ~HB_LED_OUT;

            if (change) begin
                pre       <= '0;
                cnt       <= '0;
                pos       <= '0;
                scan_down <= 1'b0;
                duty      <= '0;
                br_down   <= 1'b0;
            end else if (!HOLD_IN) begin
                pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
                if (tick) begin
                    cnt <= cnt + 1'b1;
                    // End positions turn around without dwelling twice.
                    if (N_LEDS > 1) begin
                        if (!scan_down) begin
                            if (pos == POS_LAST) begin
                                scan_down <= 1'b1;
                                pos       <= pos - 1'b1;
                            end else begin
                                pos <= pos + 1'b1;
                            end
                        end else begin
                            if (pos == '0) begin
                                scan_down <= 1'b0;
                                pos       <= pos + 1'b1;
                            end else begin
                                pos <= pos - 1'b1;
                            end
                        end
                    end
                    if (!br_down) begin
                        if (duty_up >= {1'b0, DUTY_MAX}) begin
                            duty    <= DUTY_MAX;
                            br_down <= 1'b1;
                        end else begin
                            duty <= duty_up[PWM_BITS-1:0];
                        end
                    end else begin
                        if ({1'b0, duty} <= STEP_W) begin
                            duty    <= '0;
                            br_down <= 1'b0;
                        end else begin
                            duty <= duty - STEP_W[PWM_BITS-1:0];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised self-checking bench for led_pattern_gen against a
// step-index reference model.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       hold = 1'b0;
    logic [3:0] led;
    logic       hb;
    logic       step;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: patterns derived from steps since last reload.
    int m_s1, m_s2, m_mode, m_pre, m_k, m_pwm;
    int e_led, e_step, e_hb;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .CLK_HZ(16), .STEP_HZ(4), .N_LEDS(4),
        .PWM_BITS(4), .BREATHE_STEP(5)
    ) dut (
        .CLK_IN(clk),
        .RST_N_IN(rst_n),
        .MODE_IN(mode),
        .HOLD_IN(hold),
        .LED_OUT(led),
        .HB_LED_OUT(hb),
        .STEP_OUT(step)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int duty_of(input int k);
        int d = 0;
        bit up = 1'b1;
        for (int i = 0; i < k; i++) begin
            if (up) begin
                if (d + 5 >= 15) begin d = 15; up = 1'b0; end
                else d = d + 5;
            end else begin
                if (d <= 5) begin d = 0; up = 1'b1; end
                else d = d - 5;
            end
        end
        return d;
    endfunction

    function automatic int pat(input int md, input int k, input int pwm);
        int b, p;
        b = k % 16;
        p = k % 6;
        case (md)
            0: return b;
            1: return b ^ (b >> 1);
            2: return 1 << ((p <= 3) ? p : 6 - p);
            default: return (pwm < duty_of(k)) ? 15 : 0;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_mode = 0; m_pre = 0; m_k = 0; m_pwm = 0;
        e_led = 0; e_step = 0; e_hb = 0;
    endtask

    task automatic model_step();
        int  led_n;
        bit  chg, tk;
        led_n  = pat(m_mode, m_k, m_pwm);
        chg    = (m_s2 != m_mode);
        tk     = !chg && !hold && (m_pre == 3);
        e_step = tk ? 1 : 0;
        if (tk) e_hb = e_hb ^ 1;
        if (chg) begin
            m_mode = m_s2; m_k = 0; m_pre = 0;
        end else if (!hold) begin
            m_pre = (m_pre + 1) % 4;
            if (tk) m_k++;
        end
        m_s2  = m_s1;
        m_s1  = int'(mode);
        m_pwm = (m_pwm + 1) % 16;
        e_led = led_n;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        chk("led", int'(led), e_led);
        chk("step", int'(step), e_step);
        chk("hb", int'(hb), e_hb);
    endtask

    task automatic wait_k(input int md, input int k, input string tag);
        int g = 0;
        while (!(m_mode == md && m_k == k) && g < 200) begin
            cycle();
            g++;
        end
        chk(tag, int'(g < 200), 1);
    endtask

    task automatic count_on(input string tag, input int exp);
        int on = 0;
        hold = 1'b1;
        repeat (2) cycle();
        for (int i = 0; i < 16; i++) begin
            cycle();
            on += int'(led[0]);
        end
        chk(tag, on, exp);
        hold = 1'b0;
    endtask

    initial begin
        int seen;
        int lat;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_hb", int'(hb), 0);
        chk("rst_step", int'(step), 0);
        rst_n = 1'b1;

        mode = 2'd0;
        repeat (17 * 4 + 2) cycle();

        // Asynchronous reset pulse between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led", int'(led), 0);
        chk("arst_hb", int'(hb), 0);
        chk("arst_step", int'(step), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) cycle();

        mode = 2'd1; repeat (80) cycle();
        mode = 2'd2; repeat (40) cycle();
        mode = 2'd3; repeat (40) cycle();

        // Mode change landing on a prescaler wrap cycle.
        seen = 0;
        while (m_pre != 1 && seen < 8) begin cycle(); seen++; end
        chk("coll_align", int'(seen < 8), 1);
        mode = 2'd0;
        repeat (3) cycle();
        chk("coll_nostep", int'(step), 0);
        lat = 0;
        do begin cycle(); lat++; end while (!step && lat < 20);
        chk("coll_lat", lat, 4);

        wait_k(0, 6, "hold_wait");
        hold = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            seen += int'(step);
        end
        chk("hold_step", seen, 0);
        chk("hold_led", int'(led), 6);
        hold = 1'b0;
        repeat (12) cycle();

        mode = 2'd3;
        wait_k(3, 1, "d5_wait");
        count_on("duty5_on", 5);
        wait_k(3, 3, "d15_wait");
        count_on("duty15_on", 15);
        wait_k(3, 6, "d0_wait");
        count_on("duty0_on", 0);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            cycle();
        end
        hold = 1'b0;
        repeat (10) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised LED pattern generator for the iCE40 board; next generation of the free-running clock-divider LED counter.
- Divides CLK_IN to a programmable step rate.
- Drives N_LEDS outputs in one of four runtime-selectable modes: binary, Gray, bounce scan, PWM breathe.
- Adds pattern hold, a step pulse and a heartbeat LED.

Parameters:
- CLK_HZ, 12000000: input clock frequency.
- STEP_HZ, 8: pattern step rate. DIV = CLK_HZ/STEP_HZ, integer division; elaboration error if DIV < 2.
- N_LEDS, 4: number of pattern LEDs; legal range 1..16.
- PWM_BITS, 8: PWM counter/duty width; legal range 2..12.
- BREATHE_STEP, 16: duty increment per step in breathe mode; must be >= 1 and < 2^PWM_BITS.

Ports:
- CLK_IN, input, 1: system clock.
- RST_N_IN, input, 1: asynchronous, active-low reset.
- MODE_IN, input, 2: mode select, asynchronous (switches). 0 = binary, 1 = Gray, 2 = scan, 3 = breathe.
- HOLD_IN, input, 1: freeze pattern; synchronous, already in the CLK_IN domain.
- LED_OUT, output, N_LEDS: pattern LEDs, registered.
- HB_LED_OUT, output, 1: heartbeat; toggles on every step.
- STEP_OUT, output, 1: one-cycle pulse per step, registered.

Behaviour:
Reset
- RST_N_IN low asynchronously clears all state: prescaler, pattern count, scan position, scan direction (=up), duty, breathe direction (=up), PWM counter, mode synchroniser and mode register.
- Outputs during reset: LED_OUT = 0, HB_LED_OUT = 0, STEP_OUT = 0.
- Reset release is not synchronised inside this block; the top level supplies a synchronised deassertion.

Mode input
- MODE_IN passes through a 2-flop synchroniser into mode_q.
- A change in the synchronised value:
  - reloads the pattern state to its reset values and clears the prescaler in the same cycle;
  - is effective 3 clocks after MODE_IN changes.
- No step is issued in the change cycle.

Prescaler
- Counts 0..DIV-1 and wraps.
- tick = 1 when count == DIV-1 and HOLD_IN == 0.
- HOLD_IN = 1 freezes the prescaler and all pattern state. LED_OUT holds its value; breathe PWM output keeps running at the frozen duty.
- STEP_OUT = tick, registered: one clock later, exactly 1 cycle wide.
- HB_LED_OUT toggles on each tick.

Patterns (state advances on tick only)
- Binary: N_LEDS-bit counter increments, wrapping from all-ones to 0. LED_OUT = count.
- Gray: the same counter. LED_OUT = count ^ (count >> 1).
- Scan: position pos 0..N_LEDS-1 with direction dir. LED_OUT = one-hot(pos).
  - Up: pos++. At N_LEDS-1 the next step flips dir and goes to N_LEDS-2, so the end LED lit once per pass, no double dwell.
  - Down: symmetric at 0.
  - N_LEDS == 1: pos stays 0, LED_OUT = 1.
  - Sequence for N_LEDS=4: 0,1,2,3,2,1,0,1...
- Breathe: duty register, PWM_BITS wide; MAX = 2^PWM_BITS-1.
  - Up: if duty + BREATHE_STEP >= MAX, then duty = MAX and dir = down; else duty += BREATHE_STEP.
  - Down: if duty <= BREATHE_STEP, then duty = 0 and dir = up; else duty -= BREATHE_STEP.
  - The comparison is done at PWM_BITS+1 width; no wrap.
  - A free-running PWM counter increments every clock, is never held, and wraps at MAX.
  - All LED_OUT bits = (pwm_cnt < duty), registered.
  - duty = 0 gives always off. duty = MAX gives on 2^PWM_BITS-1 of 2^PWM_BITS clocks.

Output timing
- LED_OUT reflects the state one clock after the state register updates.
- Immediately after a mode change:
  - modes 0 and 1 show 0;
  - mode 2 shows 1 (pos = 0);
  - mode 3 shows 0.

Simultaneous events
- Mode change and tick in the same cycle: the mode change wins; the tick is discarded.
- HOLD_IN and mode change in the same cycle: the mode change still reloads state.

Test Plan:
Use CLK_HZ=16, STEP_HZ=4 (DIV=4), N_LEDS=4, PWM_BITS=4, BREATHE_STEP=5.
1. Reset and STEP pulse
   - Stimulus: assert RST_N_IN low mid-run for 1 cycle (async, between clock edges).
   - Required: LED_OUT=0, HB=0, STEP=0 immediately.
   - After release, STEP_OUT pulses 1 cycle wide every 4 clocks and HB toggles on each pulse.
2. Binary and Gray
   - Stimulus: MODE=0 for 17 steps.
   - Required: LED_OUT 0,1,...,15,0.
   - Stimulus: switch to MODE=1.
   - Required: 3 clocks later LED_OUT=0, then 1,3,2,6,7,5,...
3. Scan
   - Stimulus: MODE=2.
   - Required: LED_OUT 0001,0010,0100,1000,0100,0010,0001,0010. Exactly one bit set every cycle.
4. Breathe
   - Stimulus: MODE=3.
   - Required: duty 0,5,10,15(dir down),10,5,0(dir up),5.
   - At duty=5, LED_OUT high for exactly 5 of every 16 clocks.
   - At duty=0, never high.
5. Hold
   - Stimulus: MODE=0, count=6, HOLD_IN=1 for 20 clocks.
   - Required: no STEP_OUT, LED_OUT stays 0110.
   - On release, the next step arrives after the remaining prescaler count, with no lost or extra step.
6. Mode change collides with tick
   - Stimulus: the synchronised mode change lands in a count==DIV-1 cycle.
   - Required: no STEP_OUT, state reloaded, and the next STEP_OUT comes exactly DIV clocks later.
